// File: rtl/piano_note_sequencer.sv
// rtl/piano_note_sequencer.sv - buzzer note sequencer: live keys override an autoplay song from ROM
// Optional looping playback: define PIANO_SEQ_LOOP_EN.
module piano_note_sequencer #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        keys,
    input  logic              play_start,
    input  logic              play_stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        note,
    output logic              playing,
    output logic              paused,
    output logic              done
);

    localparam int DUR_W = $clog2(15 * BEAT_CYCLES);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP, S_DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DUR_W-1:0]  dur_cnt, dur_nxt, dur_load;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt, gap_load;
    logic [3:0]        song_note, song_nxt;
    logic [3:0]        key_note, note_nxt;
    logic              key_hit, paused_nxt, done_nxt;

    assign dur_load = DUR_W'(rom_data[7:4]) * DUR_W'(BEAT_CYCLES) - DUR_W'(1);
    assign gap_load = GAP_W'(GAP_CYCLES - 1);
    assign playing  = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            song_note <= '0;
            note      <= '0;
            paused    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= addr_nxt;
            dur_cnt   <= dur_nxt;
            gap_cnt   <= gap_nxt;
            song_note <= song_nxt;
            note      <= note_nxt;
            paused    <= paused_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        dur_nxt   = dur_cnt;
        gap_nxt   = gap_cnt;
        song_nxt  = song_note;
        done_nxt  = 1'b0;
        key_hit   = |keys;
        key_note  = 4'd0;
        // Scan downward so the lowest pressed key is the last one written.
        for (int i = 6; i >= 0; i--) begin
            if (keys[i]) key_note = 4'(i + 1);
        end

        if (play_stop) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (play_start) begin
                        state_nxt = S_FETCH;
                        addr_nxt  = '0;
                    end
                end
                S_FETCH: begin
                    if (!key_hit) begin
                        if (rom_data[7:4] == 4'd0) begin
                            done_nxt = 1'b1;
`ifdef PIANO_SEQ_LOOP_EN
                            if (rom_addr != '0) begin
                                addr_nxt  = '0;
                                state_nxt = S_FETCH;
                            end else begin
                                state_nxt = S_DONE;
                            end
`else
                            state_nxt = S_DONE;
`endif
                        end else begin
                            dur_nxt   = dur_load;
                            song_nxt  = rom_data[3] ? 4'd0 : rom_data[3:0];
                            state_nxt = S_NOTE;
                        end
                    end
                end
                S_NOTE: begin
                    if (!key_hit) begin
                        if (dur_cnt != '0) begin
                            dur_nxt = dur_cnt - DUR_W'(1);
                        end else if (GAP_CYCLES == 0) begin
                            addr_nxt  = rom_addr + ADDR_W'(1);
                            state_nxt = S_FETCH;
                        end else begin
                            gap_nxt   = gap_load;
                            state_nxt = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (!key_hit) begin
                        if (gap_cnt != '0) begin
                            gap_nxt = gap_cnt - GAP_W'(1);
                        end else begin
                            addr_nxt  = rom_addr + ADDR_W'(1);
                            state_nxt = S_FETCH;
                        end
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end

        if (key_hit)
            note_nxt = key_note;
        else if (state == S_NOTE && !play_stop)
            note_nxt = song_note;
        else
            note_nxt = 4'd0;

        paused_nxt = key_hit && !play_stop &&
                     (state == S_FETCH || state == S_NOTE || state == S_GAP);
    end

endmodule

// File: tb/tb_piano_note_sequencer.sv
// tb/tb_piano_note_sequencer.sv - self-checking bench for piano_note_sequencer
module tb_piano_note_sequencer;

    localparam int BEAT = 4;
    localparam int GAP  = 2;

    logic       clk, rst, play_start, play_stop, playing, paused, done;
    logic [6:0] keys;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic [3:0] note;
    logic [7:0] rom [0:63];

    assign rom_data = rom[rom_addr];

    piano_note_sequencer #(.BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .keys(keys), .play_start(play_start), .play_stop(play_stop),
        .rom_addr(rom_addr), .rom_data(rom_data), .note(note), .playing(playing),
        .paused(paused), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cnt_n1, cnt_n3, cnt_done, cnt_paused, cnt_silent_play;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the song unrolled into one timeline entry per clock cycle.
    typedef struct packed {
        logic       pausable;
        logic       is_note;
        logic [3:0] snote;
        logic [5:0] addr;
        logic       done_s;
    } item_t;

    item_t      tl[$];
    item_t      cur;
    logic       act;
    logic [5:0] last_addr, m_addr;
    logic [3:0] m_note;
    logic       m_paused, m_playing, m_done;

    function automatic logic [3:0] lowest_key(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    task automatic build_song();
        int a, passes;
        item_t it;
        logic [7:0] e;
        a = 0;
        passes = 0;
        while (passes < 4) begin
            e = rom[a];
            it = '0;
            it.pausable = 1'b1;
            it.addr = 6'(a);
            it.done_s = (a == 0 && passes > 0);
            tl.push_back(it);
            if (e[7:4] == 4'd0) begin
`ifdef PIANO_SEQ_LOOP_EN
                if (a != 0) begin
                    a = 0;
                    passes++;
                    continue;
                end
`endif
                it = '0;
                it.addr = 6'(a);
                it.done_s = 1'b1;
                tl.push_back(it);
                break;
            end
            for (int i = 0; i < int'(e[7:4]) * BEAT; i++) begin
                it = '0;
                it.pausable = 1'b1;
                it.is_note = 1'b1;
                it.snote = (e[3:0] > 4'd7) ? 4'd0 : e[3:0];
                it.addr = 6'(a);
                tl.push_back(it);
            end
            for (int i = 0; i < GAP; i++) begin
                it = '0;
                it.pausable = 1'b1;
                it.addr = 6'(a);
                tl.push_back(it);
            end
            a = (a + 1) % 64;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tl.delete();
            last_addr = '0;
            m_addr = '0; m_note = '0; m_paused = 0; m_playing = 0; m_done = 0;
        end else begin
            act = (tl.size() > 0);
            cur = act ? tl[0] : '0;
            m_note = (|keys) ? lowest_key(keys) : ((act && cur.is_note && !play_stop) ? cur.snote : 4'd0);
            m_paused = (|keys) && act && cur.pausable && !play_stop;
            if (play_stop) begin
                if (act) last_addr = cur.addr;
                tl.delete();
            end else if (!act) begin
                if (play_start) build_song();
            end else if (!((|keys) && cur.pausable)) begin
                last_addr = cur.addr;
                void'(tl.pop_front());
            end
            if (tl.size() > 0) begin
                m_playing = 1'b1;
                m_addr = tl[0].addr;
                m_done = tl[0].done_s;
            end else begin
                m_playing = 1'b0;
                m_addr = last_addr;
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("note", {4'd0, note}, {4'd0, m_note});
        chk("playing", {7'd0, playing}, {7'd0, m_playing});
        chk("paused", {7'd0, paused}, {7'd0, m_paused});
        chk("done", {7'd0, done}, {7'd0, m_done});
        chk("rom_addr", {2'd0, rom_addr}, {2'd0, m_addr});
        if (note == 4'd1) cnt_n1++;
        if (note == 4'd3) cnt_n3++;
        if (done) cnt_done++;
        if (paused) cnt_paused++;
        if (playing && note == 4'd0) cnt_silent_play++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_counts();
        cnt_n1 = 0; cnt_n3 = 0; cnt_done = 0; cnt_paused = 0; cnt_silent_play = 0;
    endtask

    task automatic start_pulse();
        play_start = 1'b1;
        tick(1);
        play_start = 1'b0;
    endtask

    task automatic stop_pulse();
        play_stop = 1'b1;
        tick(1);
        play_stop = 1'b0;
    endtask

    task automatic load_default_rom();
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        rom[0] = 8'h21;
        rom[1] = 8'h13;
        rom[2] = 8'h00;
    endtask

    initial begin
        rst = 1'b1; keys = '0; play_start = 1'b0; play_stop = 1'b0;
        clear_counts();
        load_default_rom();
        tick(2);
        chk("reset_note", {4'd0, note}, 8'd0);
        chk("reset_playing", {7'd0, playing}, 8'd0);
        chk("reset_addr", {2'd0, rom_addr}, 8'd0);
        rst = 1'b0;
        tick(2);

        // Plain song playback
        clear_counts();
        start_pulse();
        tick(24);
        chk("t1_note1_cycles", 8'(cnt_n1), 8'd8);
        chk("t1_note3_cycles", 8'(cnt_n3), 8'd4);
        chk("t1_done_pulses", 8'(cnt_done), 8'd1);
        chk("t1_playing_end", {7'd0, playing}, 8'd0);

        // Keys held mid-note pause the song
        clear_counts();
        start_pulse();
        tick(3);
        keys = 7'b0010100;
        tick(10);
        keys = '0;
        tick(30);
        chk("t2_note1_cycles", 8'(cnt_n1), 8'd8);
        chk("t2_note3_cycles", 8'(cnt_n3), 8'd14);
        chk("t2_paused_cycles", 8'(cnt_paused), 8'd10);
        chk("t2_done_pulses", 8'(cnt_done), 8'd1);

        // Stop in the second gap, together with a start that must lose
        clear_counts();
        start_pulse();
        tick(16);
        play_stop = 1'b1;
        play_start = 1'b1;
        tick(1);
        play_stop = 1'b0;
        play_start = 1'b0;
        chk("t3_playing", {7'd0, playing}, 8'd0);
        chk("t3_note", {4'd0, note}, 8'd0);
        tick(2);
        chk("t3_done_pulses", 8'(cnt_done), 8'd0);
        start_pulse();
        chk("t3_restart_addr", {2'd0, rom_addr}, 8'd0);
        chk("t3_restart_playing", {7'd0, playing}, 8'd1);
        stop_pulse();
        tick(2);

        // Asynchronous reset during the second note
        clear_counts();
        start_pulse();
        tick(14);
        chk("t4_pre_addr", {2'd0, rom_addr}, 8'd1);
        chk("t4_pre_note", {4'd0, note}, 8'd3);
        #2 rst = 1'b1;
        #1;
        chk("t4_async_note", {4'd0, note}, 8'd0);
        chk("t4_async_playing", {7'd0, playing}, 8'd0);
        chk("t4_async_addr", {2'd0, rom_addr}, 8'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("t4_done_pulses", 8'(cnt_done), 8'd0);

`ifdef PIANO_SEQ_LOOP_EN
        // Looping: end marker restarts at address 0 with a done pulse per pass
        clear_counts();
        start_pulse();
        tick(44);
        chk("t5_loop_done_pulses", 8'(cnt_done), 8'd2);
        chk("t5_loop_playing", {7'd0, playing}, 8'd1);
        stop_pulse();
        tick(2);
`endif

        // End marker at address 0: single done pulse, back to idle
        clear_counts();
        rom[0] = 8'h00;
        start_pulse();
        tick(5);
        chk("t5_empty_done", 8'(cnt_done), 8'd1);
        chk("t5_empty_playing", {7'd0, playing}, 8'd0);

        // Longest entry, note code 9 played as rest
        clear_counts();
        rom[0] = 8'hF9;
        rom[1] = 8'h00;
        start_pulse();
        tick(63);
        chk("t6_addr_advance", {2'd0, rom_addr}, 8'd1);
        chk("t6_silent_playing", 8'(cnt_silent_play), 8'd64);
        tick(5);
        chk("t6_done_pulses", 8'(cnt_done), 8'd1);
        chk("t6_idle", {7'd0, playing}, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
